// File: rtl/wide_mult_sequencer_pkg.sv
// Shared types for the sequenced wide multiplier: FSM states, step count and
// the per-step shift amount applied to each narrow partial product.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, MUL, DONE} mseq_state_t;

    localparam int MSEQ_STEPS = 4;

    // Step k multiplies (aL|aH) x (bL|bH); cross terms land one half-width up.
    function automatic int shift_amt(input logic [1:0] k, input int size);
        case (k)
            2'd0:    return 0;
            2'd3:    return 2 * size;
            default: return size;
        endcase
    endfunction

endpackage

// File: rtl/wide_mult_sequencer_tree.sv
// Combinational SIZE x SIZE unsigned multiplier: gated partial products summed
// through a balanced binary adder tree (heap-indexed, works for any SIZE).
module tree_multiplier #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0]   x,
    input  logic [SIZE-1:0]   y,
    output logic [2*SIZE-1:0] p
);

    localparam int PW    = 2 * SIZE;
    localparam int NODES = 2 * SIZE - 1;

    // Nodes 0..SIZE-2 are adders, nodes SIZE-1..2*SIZE-2 are the partial-product leaves.
    for (genvar n = 0; n < NODES; n++) begin : g_node
        logic [PW-1:0] s;
        if (n >= SIZE - 1) begin : g_leaf
            assign s = y[n-(SIZE-1)] ? ({{SIZE{1'b0}}, x} << (n - (SIZE - 1))) : '0;
        end else begin : g_sum
            assign s = g_node[2*n+1].s + g_node[2*n+2].s;
        end
    end

    assign p = g_node[0].s;

endmodule

// File: rtl/wide_mult_sequencer.sv
// 2*SIZE x 2*SIZE unsigned multiply over four passes of one SIZE x SIZE tree.
// Result 4 cycles after accept; DONE holds the product until out_ready, in_ready low meanwhile.
module wide_mult_sequencer
    import mult_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*SIZE-1:0] a,
    input  logic [2*SIZE-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*SIZE-1:0] product,
    output logic              busy
);

    localparam int OW = 2 * SIZE;
    localparam int PW = 4 * SIZE;
    localparam logic [1:0] LAST_STEP = 2'(MSEQ_STEPS - 1);

    mseq_state_t     state_q;
    logic [1:0]      step_q;
    logic [OW-1:0]   a_q;
    logic [OW-1:0]   b_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   acc_d;

    logic [SIZE-1:0] mul_x;
    logic [SIZE-1:0] mul_y;
    logic [OW-1:0]   pp;
    logic            accept;

    // step[1] picks the half of a, step[0] the half of b: 0=LL, 1=LH, 2=HL, 3=HH.
    assign mul_x = step_q[1] ? a_q[OW-1:SIZE] : a_q[SIZE-1:0];
    assign mul_y = step_q[0] ? b_q[OW-1:SIZE] : b_q[SIZE-1:0];

    tree_multiplier #(.SIZE(SIZE)) u_tree (
        .x (mul_x),
        .y (mul_y),
        .p (pp)
    );

    assign acc_d = acc_q + ({{OW{1'b0}}, pp} << shift_amt(step_q, SIZE));

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign product   = acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // A DONE retire and a fresh accept share one edge: no IDLE bubble.
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        step_q  <= '0;
                        state_q <= MUL;
                    end else if ((state_q == DONE) && out_ready) begin
                        state_q <= IDLE;
                    end
                end
                MUL: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 2'd1;
                    if (step_q == LAST_STEP) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_mult_sequencer.sv
// Bench for wide_mult_sequencer (SIZE=8): directed corner operands plus random
// pairs, checked against a plain-arithmetic product model.
module tb_wide_mult_sequencer;

    localparam int SIZE = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wide_mult_sequencer #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        longint unsigned r;
        r = longint'(x) * longint'(y);
        return r[31:0];
    endfunction

    // Starts 1 time unit after a rising edge with the DUT idle; returns once
    // out_valid is seen (left in DONE with out_ready low) or the budget expires.
    task automatic send_and_wait(input logic [15:0] x, input logic [15:0] y,
                                 output logic [31:0] p, output int lat, output bit ok);
        a = x;
        b = y;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        ok  = 1'b0;
        p   = '0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                p  = product;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || product !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: out_valid=%b product=%h busy=%b in_ready=%b, want 0 0 0 1",
                     out_valid, product, busy, in_ready);
        end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string name, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        int          lat;
        bit          ok;
        send_and_wait(x, y, p, lat, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s timeout: no out_valid within budget", name);
        end else begin
            if (p !== ref_mul(x, y)) begin
                miscompares++;
                $display("FAIL %s product: got %h want %h", name, p, ref_mul(x, y));
            end
            vectors++;
            if (lat !== 4) begin
                miscompares++;
                $display("FAIL %s latency: got %0d want 4", name, lat);
            end
            vectors++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s done_flags: busy=%b in_ready=%b want 1 0", name, busy, in_ready);
            end
        end
        retire();
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s retire: out_valid=%b busy=%b want 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_basic;
        check_op("basic", 16'h1234, 16'h5678);
    endtask

    task automatic test_max;
        check_op("max", 16'hFFFF, 16'hFFFF);
    endtask

    task automatic test_zero_identity;
        check_op("zero", 16'h0000, 16'hBEEF);
        check_op("identity", 16'h0001, 16'hBEEF);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            check_op("random", 16'($urandom), 16'($urandom));
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] p;
        logic [31:0] want;
        int          lat;
        bit          ok;
        logic [15:0] x;
        logic [15:0] y;
        x    = 16'($urandom);
        y    = 16'($urandom);
        want = ref_mul(x, y);
        send_and_wait(x, y, p, lat, ok);
        vectors++;
        if (!ok || p !== want) begin
            miscompares++;
            $display("FAIL bp_first: ok=%b product=%h want %h", ok, p, want);
        end
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || product !== want || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b product=%h in_ready=%b want 1 %h 0",
                         i, out_valid, product, in_ready, want);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_single_handshake: out_valid=%b want 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        logic [31:0] exp_q[$];
        logic [31:0] want;
        int          idx;
        int          got;
        int          last_cyc;
        bit          acc_now;
        idx      = 0;
        got      = 0;
        last_cyc = -1;
        for (int i = 0; i < 3; i++) begin
            qa.push_back(16'($urandom));
            qb.push_back(16'($urandom));
        end
        out_ready = 1'b1;
        a = qa[0];
        b = qb[0];
        in_valid = 1'b1;
        #1;
        for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            acc_now = in_valid && in_ready;
            if (out_valid === 1'b1) begin
                want = exp_q.size() > 0 ? exp_q.pop_front() : 32'hx;
                vectors++;
                if (product !== want) begin
                    miscompares++;
                    $display("FAIL b2b result %0d: got %h want %h", got, product, want);
                end
                if (last_cyc >= 0) begin
                    vectors++;
                    if (cyc - last_cyc != 5) begin
                        miscompares++;
                        $display("FAIL b2b spacing: got %0d cycles want 5", cyc - last_cyc);
                    end
                end
                if (in_valid) begin
                    vectors++;
                    if (in_ready !== 1'b1) begin
                        miscompares++;
                        $display("FAIL b2b same_edge_ready: in_ready=%b want 1", in_ready);
                    end
                end
                last_cyc = cyc;
                got++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                exp_q.push_back(ref_mul(qa[idx], qb[idx]));
                idx++;
                if (idx < 3) begin
                    a = qa[idx];
                    b = qb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (idx > 0 && got < 3) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b no_idle cycle %0d: busy=%b want 1", cyc, busy);
                end
            end
            #1;
        end
        vectors++;
        if (got != 3) begin
            miscompares++;
            $display("FAIL b2b count: got %0d results want 3", got);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul;
        bit stale;
        a = 16'hFFFF;
        b = 16'hABCD;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || product !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid: out_valid=%b product=%h busy=%b in_ready=%b want 0 0 0 1",
                     out_valid, product, busy, in_ready);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        vectors++;
        if (stale) begin
            miscompares++;
            $display("FAIL rst_stale: result or activity seen after reset, want none");
        end
        out_ready = 1'b0;
        check_op("rst_after", 16'($urandom), 16'($urandom));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero_identity();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wide_mult_sequencer.md
# wide_mult_sequencer

Sequenced unsigned multiplier that computes a 2·SIZE × 2·SIZE product by reusing one combinational SIZE × SIZE `tree_multiplier` over four cycles. Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. Lets the ALU offer double-width multiplication without a double-width tree: four narrow partial products are accumulated in a 4·SIZE-bit register.

## Interface
Parameters:
- `SIZE`, default 8: width of the shared narrow multiplier. Operands are 2·SIZE bits; the product is 4·SIZE bits.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  2·SIZE: unsigned multiplicand.
- `b`  in  2·SIZE: unsigned multiplier.
- `out_valid`  out  1: `product` is valid.
- `out_ready`  in  1: consumer accepts the product.
- `product`  out  4·SIZE: a·b, exact, unsigned.
- `busy`  out  1: high in MUL or DONE.

## Operation
- FSM has three states:
  - IDLE: waiting for operands.
  - MUL: four steps, counted by a 2-bit counter `step` running 0..3.
  - DONE: holding the result.
- Input handshake and operand capture:
  - Accept when `in_valid && in_ready` at a clock edge.
  - On accept, latch `a` and `b` into operand registers, clear the accumulator, set `step=0`, go to MUL.
  - `a` and `b` are ignored at all other times.
- MUL step k feeds the halves below to the shared multiplier. Each partial product is 2·SIZE bits, zero-extended to 4·SIZE before the shift.
  - k=0: aL·bL, shift 0.
  - k=1: aL·bH, shift SIZE.
  - k=2: aH·bL, shift SIZE.
  - k=3: aH·bH, shift 2·SIZE.
- Accumulate and advance:
  - Each step: acc ← acc + (pp << shift), in 4·SIZE-bit arithmetic. The final sum never overflows.
  - `step` increments each MUL cycle. At step 3, go to DONE.
- DONE: `out_valid=1`, `product=acc`, both held stable until `out_ready`.
- `in_ready = (state==IDLE) || (state==DONE && out_ready)`.
  - Output handshake and new accept on the same edge: result retires, new operands latch, FSM goes straight to MUL step 0.
  - Output handshake with no new input: FSM goes to IDLE.
- `out_ready` is ignored outside DONE.
- Reset, asynchronous and usable at any time including mid-MUL:
  - state=IDLE, step=0, operands=0, acc=0.
  - `out_valid=0`, `product=0`, `busy=0`, `in_ready=1`.
  - Any in-flight operation is discarded and no result is ever presented for it.

## Timing
- Accept at edge E0. MUL occupies the cycles after E0, E1, E2 and E3. `out_valid` rises after E4: latency is 4 cycles from the accept edge.
- Sustained throughput with `out_ready` tied high: one result per 5 cycles.
  - Accept at E0, result handshake plus next accept at E5.
- `product` and `out_valid` come directly from registers.
- Combinational paths:
  - `in_ready` depends combinationally on `out_ready` in DONE.
  - Critical path: operand mux → tree_multiplier → 4·SIZE adder → acc.
- Backpressure: DONE holds indefinitely with `product` stable. `in_ready` stays 0 while `out_ready` is 0.

## Structure
- Shared package `mult_pkg`:
  - `typedef enum logic [1:0] {IDLE, MUL, DONE} mseq_state_t`.
  - `localparam MSEQ_STEPS = 4`.
  - The shift-amount function of (k, SIZE).
- Sub-module: exactly one `tree_multiplier #(.SIZE(SIZE))` instance, fed by the step-indexed operand muxes.
- No other sub-modules. The adder and accumulator are inline.

## Test plan
- Basic product, SIZE=8: a=0x1234, b=0x5678 → `product=0x06260060`; `out_valid` high 4 cycles after the accept edge.
- Maximum operands: a=b=0xFFFF → `product=0xFFFE0001`. Checks carry propagation and the no-overflow claim.
- Zero and identity: a=0, b=0xBEEF → 0; then a=1, b=0xBEEF → 0x0000BEEF.
- Backpressure: hold `out_ready=0` for 10 cycles in DONE. `product` and `out_valid` stay stable, `in_ready=0` with `in_valid=1`, no operand capture. Release `out_ready` → one handshake only.
- Back-to-back: `out_ready=1`, `in_valid=1` streaming 3 random pairs.
  - Results arrive in order, 5 cycles apart.
  - Each pass through DONE with a waiting input shows the same-edge retire and accept, with no IDLE cycle.
- Reset mid-MUL: assert `rst` asynchronously during step 2 (between edges).
  - Outputs go to reset values immediately.
  - After release, the next accepted pair produces the correct product and no stale result ever appears.
